// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode/funct encodings, ALU op enum and datapath defaults.
package cpu_pkg;

  localparam int unsigned DEF_DATA_W = 32;
  localparam int unsigned DEF_REG_AW = 5;

  // Primary opcodes, instr[31:26]
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;
  localparam logic [5:0] OP_BEQ   = 6'h04;

  // R-type function codes, instr[5:0]
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_SUB = 6'h22;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  typedef enum logic [2:0] {
    AluAdd = 3'd0,
    AluSub = 3'd1,
    AluAnd = 3'd2,
    AluOr  = 3'd3,
    AluSlt = 3'd4
  } alu_op_t;

endpackage

// File: rtl/decode_stage_if.sv
// Decode-stage bus: fetch-side instruction, write-back port and ID/EX outputs.
interface decode_stage_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5
);

  logic [31:0]       i_instruction;
  logic              i_valid;
  logic              i_stall;
  logic              i_flush;
  logic              i_wb_en;
  logic [REG_AW-1:0] i_wb_addr;
  logic [DATA_W-1:0] i_wb_data;

  logic              o_valid;
  logic [DATA_W-1:0] o_rs_data;
  logic [DATA_W-1:0] o_rt_data;
  logic [DATA_W-1:0] o_imm;
  logic [REG_AW-1:0] o_rd_addr;
  logic [2:0]        o_alu_op;
  logic              o_use_imm;
  logic              o_reg_write;
  logic              o_mem_read;
  logic              o_mem_write;
  logic              o_branch;
  logic              o_illegal;

  // Upstream side (fetch / write-back / pipeline control)
  modport master (
    output i_instruction, i_valid, i_stall, i_flush, i_wb_en, i_wb_addr, i_wb_data,
    input  o_valid, o_rs_data, o_rt_data, o_imm, o_rd_addr, o_alu_op, o_use_imm,
           o_reg_write, o_mem_read, o_mem_write, o_branch, o_illegal
  );

  // Decode stage itself
  modport slave (
    input  i_instruction, i_valid, i_stall, i_flush, i_wb_en, i_wb_addr, i_wb_data,
    output o_valid, o_rs_data, o_rt_data, o_imm, o_rd_addr, o_alu_op, o_use_imm,
           o_reg_write, o_mem_read, o_mem_write, o_branch, o_illegal
  );

endinterface

// File: rtl/regfile.sv
// 2R/1W register file, r0 hardwired to zero, write-to-read bypass on both read ports.
module regfile
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_AW = DEF_REG_AW
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_we,
  input  logic [REG_AW-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [REG_AW-1:0] i_raddr_a,
  input  logic [REG_AW-1:0] i_raddr_b,
  output logic [DATA_W-1:0] o_rdata_a,
  output logic [DATA_W-1:0] o_rdata_b
);

  localparam int unsigned NumRegs = 2 ** REG_AW;

  logic [DATA_W-1:0] r_regs [NumRegs];

  // Storage: clear all on reset, write non-zero index on the clock edge
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < NumRegs; i++) begin
        r_regs[i] <= '0;
      end
    end else if (i_we && (i_waddr != '0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  // Read port A: r0 reads zero, an in-flight write to the same index is forwarded
  always_comb begin
    o_rdata_a = r_regs[i_raddr_a];
    if (i_raddr_a == '0) begin
      o_rdata_a = '0;
    end else if (i_we && (i_waddr == i_raddr_a)) begin
      o_rdata_a = i_wdata;
    end
  end

  // Read port B: same policy as port A
  always_comb begin
    o_rdata_b = r_regs[i_raddr_b];
    if (i_raddr_b == '0) begin
      o_rdata_b = '0;
    end else if (i_we && (i_waddr == i_raddr_b)) begin
      o_rdata_b = i_wdata;
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Instruction decode: field split, operand read, control decode and ID/EX register.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned REG_AW = DEF_REG_AW
) (
  input logic           i_clk,
  input logic           i_reset,
  decode_stage_if.slave bus
);

  // Field split
  logic [5:0]        w_opcode;
  logic [5:0]        w_funct;
  logic [REG_AW-1:0] w_rs;
  logic [REG_AW-1:0] w_rt;
  logic [REG_AW-1:0] w_rd;
  logic [DATA_W-1:0] w_imm;
  logic              w_is_nop;

  assign w_opcode = bus.i_instruction[31:26];
  assign w_funct  = bus.i_instruction[5:0];
  assign w_rs     = bus.i_instruction[25:21];
  assign w_rt     = bus.i_instruction[20:16];
  assign w_rd     = bus.i_instruction[15:11];
  assign w_imm    = {{(DATA_W - 16){bus.i_instruction[15]}}, bus.i_instruction[15:0]};
  assign w_is_nop = (bus.i_instruction == '0);

  // Operand read
  logic [DATA_W-1:0] w_rs_data;
  logic [DATA_W-1:0] w_rt_data;

  regfile #(
    .DATA_W (DATA_W),
    .REG_AW (REG_AW)
  ) u_regfile (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .i_we      (bus.i_wb_en),
    .i_waddr   (bus.i_wb_addr),
    .i_wdata   (bus.i_wb_data),
    .i_raddr_a (w_rs),
    .i_raddr_b (w_rt),
    .o_rdata_a (w_rs_data),
    .o_rdata_b (w_rt_data)
  );

  // Decoded control
  alu_op_t           w_alu_op;
  logic [REG_AW-1:0] w_rd_addr;
  logic              w_use_imm;
  logic              w_reg_write;
  logic              w_mem_read;
  logic              w_mem_write;
  logic              w_branch;
  logic              w_illegal;

  // Control decode; invalid slots and the all-zero NOP leave every control bit low
  always_comb begin
    w_alu_op    = AluAdd;
    w_rd_addr   = '0;
    w_use_imm   = 1'b0;
    w_reg_write = 1'b0;
    w_mem_read  = 1'b0;
    w_mem_write = 1'b0;
    w_branch    = 1'b0;
    w_illegal   = 1'b0;
    if (bus.i_valid && !w_is_nop) begin
      case (w_opcode)
        OP_RTYPE: begin
          w_rd_addr   = w_rd;
          w_reg_write = 1'b1;
          case (w_funct)
            FUNCT_ADD: w_alu_op = AluAdd;
            FUNCT_SUB: w_alu_op = AluSub;
            FUNCT_AND: w_alu_op = AluAnd;
            FUNCT_OR:  w_alu_op = AluOr;
            FUNCT_SLT: w_alu_op = AluSlt;
            default:   w_illegal = 1'b1;
          endcase
        end
        OP_ADDI: begin
          w_rd_addr   = w_rt;
          w_use_imm   = 1'b1;
          w_reg_write = 1'b1;
        end
        OP_LW: begin
          w_rd_addr   = w_rt;
          w_use_imm   = 1'b1;
          w_reg_write = 1'b1;
          w_mem_read  = 1'b1;
        end
        OP_SW: begin
          w_rd_addr   = w_rt;
          w_use_imm   = 1'b1;
          w_mem_write = 1'b1;
        end
        OP_BEQ: begin
          w_branch = 1'b1;
          w_alu_op = AluSub;
        end
        default: w_illegal = 1'b1;
      endcase
      // An illegal instruction must not leak any partial control
      if (w_illegal) begin
        w_alu_op    = AluAdd;
        w_rd_addr   = '0;
        w_use_imm   = 1'b0;
        w_reg_write = 1'b0;
        w_mem_read  = 1'b0;
        w_mem_write = 1'b0;
        w_branch    = 1'b0;
      end
    end
  end

  // ID/EX register
  logic              r_valid;
  logic [DATA_W-1:0] r_rs_data;
  logic [DATA_W-1:0] r_rt_data;
  logic [DATA_W-1:0] r_imm;
  logic [REG_AW-1:0] r_rd_addr;
  alu_op_t           r_alu_op;
  logic              r_use_imm;
  logic              r_reg_write;
  logic              r_mem_read;
  logic              r_mem_write;
  logic              r_branch;
  logic              r_illegal;

  // Pipeline register: reset > flush > stall (hold) > load
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset || bus.i_flush) begin
      r_valid     <= 1'b0;
      r_rs_data   <= '0;
      r_rt_data   <= '0;
      r_imm       <= '0;
      r_rd_addr   <= '0;
      r_alu_op    <= AluAdd;
      r_use_imm   <= 1'b0;
      r_reg_write <= 1'b0;
      r_mem_read  <= 1'b0;
      r_mem_write <= 1'b0;
      r_branch    <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (!bus.i_stall) begin
      r_valid     <= bus.i_valid;
      r_rs_data   <= w_rs_data;
      r_rt_data   <= w_rt_data;
      r_imm       <= w_imm;
      r_rd_addr   <= w_rd_addr;
      r_alu_op    <= w_alu_op;
      r_use_imm   <= w_use_imm;
      r_reg_write <= w_reg_write;
      r_mem_read  <= w_mem_read;
      r_mem_write <= w_mem_write;
      r_branch    <= w_branch;
      r_illegal   <= w_illegal;
    end
  end

  assign bus.o_valid     = r_valid;
  assign bus.o_rs_data   = r_rs_data;
  assign bus.o_rt_data   = r_rt_data;
  assign bus.o_imm       = r_imm;
  assign bus.o_rd_addr   = r_rd_addr;
  assign bus.o_alu_op    = r_alu_op;
  assign bus.o_use_imm   = r_use_imm;
  assign bus.o_reg_write = r_reg_write;
  assign bus.o_mem_read  = r_mem_read;
  assign bus.o_mem_write = r_mem_write;
  assign bus.o_branch    = r_branch;
  assign bus.o_illegal   = r_illegal;

endmodule
